// File: rtl/run_controller_if.sv
// Host-facing request/response channel of the run controller.
// The host drives the master modport; the controller uses the slave modport.
interface run_controller_if #(
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic             abort;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [CNT_W-1:0] rsp_cycles;
  logic             rsp_timeout;
  logic             rsp_aborted;

  modport master (
    output req_valid, abort, rsp_ready,
    input  req_ready, rsp_valid, rsp_cycles, rsp_timeout, rsp_aborted
  );

  modport slave (
    input  req_valid, abort, rsp_ready,
    output req_ready, rsp_valid, rsp_cycles, rsp_timeout, rsp_aborted
  );
endinterface

// File: rtl/run_controller.sv
// Host-side sequencer: holds the core in start for a fixed number of cycles,
// counts execution cycles until done/abort/timeout and reports the result.
module run_controller #(
  parameter int CNT_W        = 16,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  run_controller_if.slave  host,
  output logic             start,
  input  logic             done,
  output logic             busy
);

  localparam int SC_W = 4;
  localparam logic [SC_W-1:0]  LAST_SC = SC_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_RUN    = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [SC_W-1:0]  scnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_now;

  logic             start_q, busy_q, rsp_vld_q;
  logic             start_d, busy_d, rsp_vld_d;
  logic [CNT_W-1:0] rsp_cycles_q;
  logic             rsp_timeout_q, rsp_aborted_q;

  logic             lat_en;
  logic [CNT_W-1:0] lat_cycles;
  logic             lat_timeout, lat_aborted;

  // cnt_q holds completed RUN cycles, so the cycle being evaluated is cnt_q + 1
  assign cnt_now = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      scnt_q        <= '0;
      cnt_q         <= '0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      rsp_vld_q     <= 1'b0;
      rsp_cycles_q  <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      rsp_vld_q <= rsp_vld_d;
      scnt_q    <= (state_q == S_START) ? scnt_q + SC_W'(1) : '0;
      cnt_q     <= (state_q == S_RUN)   ? cnt_now           : '0;
      if (lat_en) begin
        rsp_cycles_q  <= lat_cycles;
        rsp_timeout_q <= lat_timeout;
        rsp_aborted_q <= lat_aborted;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (host.req_valid) state_d = S_START;
      S_START: begin
        if (host.abort)            state_d = S_REPORT;
        else if (scnt_q == LAST_SC) state_d = S_RUN;
      end
      S_RUN:    if (done || host.abort || (cnt_now == TO_CNT)) state_d = S_REPORT;
      S_REPORT: if (host.rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered outputs follow the next state; result fields use done > abort > timeout.
  always_comb begin
    start_d     = (state_d == S_START);
    busy_d      = (state_d == S_START) || (state_d == S_RUN);
    rsp_vld_d   = (state_d == S_REPORT);
    lat_en      = 1'b0;
    lat_cycles  = '0;
    lat_timeout = 1'b0;
    lat_aborted = 1'b0;
    if (state_q == S_START && host.abort) begin
      lat_en      = 1'b1;
      lat_aborted = 1'b1;
    end else if (state_q == S_RUN) begin
      if (done) begin
        lat_en     = 1'b1;
        lat_cycles = cnt_now;
      end else if (host.abort) begin
        lat_en      = 1'b1;
        lat_cycles  = cnt_now;
        lat_aborted = 1'b1;
      end else if (cnt_now == TO_CNT) begin
        lat_en      = 1'b1;
        lat_cycles  = cnt_now;
        lat_timeout = 1'b1;
      end
    end
  end

  assign start            = start_q;
  assign busy             = busy_q;
  assign host.req_ready   = (state_q == S_IDLE);
  assign host.rsp_valid   = rsp_vld_q;
  assign host.rsp_cycles  = rsp_cycles_q;
  assign host.rsp_timeout = rsp_timeout_q;
  assign host.rsp_aborted = rsp_aborted_q;

endmodule

// File: tb/tb_run_controller.sv
// Randomized and directed bench for run_controller against a run-outcome model.
module tb_run_controller;

  localparam int CNT_W        = 16;
  localparam int START_CYCLES = 2;
  localparam int TIMEOUT      = 1000;
  localparam int NEVER        = 1 << 30;

  logic clk;
  logic rst_n;
  logic start;
  logic done;
  logic busy;

  int vectors;
  int miscompares;

  run_controller_if #(.CNT_W(CNT_W)) h ();

  run_controller #(
    .CNT_W(CNT_W), .START_CYCLES(START_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .host(h.slave),
    .start(start), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Outcome of a run from the event times: earliest event wins, done > abort > timeout.
  function automatic void model(input int d_at, input int a_at, input int ast,
                                output int cyc, output bit to, output bit ab);
    int td, ta;
    td = (d_at > 0) ? d_at : NEVER;
    ta = (a_at > 0) ? a_at : NEVER;
    to = 1'b0;
    ab = 1'b0;
    if (ast > 0 && ast <= START_CYCLES) begin
      cyc = 0; ab = 1'b1;
    end else if (td <= ta && td <= TIMEOUT) begin
      cyc = td;
    end else if (ta <= TIMEOUT) begin
      cyc = ta; ab = 1'b1;
    end else begin
      cyc = TIMEOUT; to = 1'b1;
    end
  endfunction

  task automatic do_run(input int d_at, input int a_at, input int ast, input bit spur,
                        input int bp, input bit hold_req, input int rst_at);
    int exp_cyc;
    bit exp_to, exp_ab;
    int r;
    logic [CNT_W-1:0] c0;
    logic t0, a0;
    model(d_at, a_at, ast, exp_cyc, exp_to, exp_ab);

    check_eq("idle_req_ready", h.req_ready, 1);
    check_eq("idle_start", start, 0);
    h.req_valid = 1'b1;
    @(posedge clk); #1;
    h.req_valid = 1'b0;

    for (int sc = 1; sc <= START_CYCLES; sc++) begin
      check_eq("start_hi", start, 1);
      check_eq("start_busy", busy, 1);
      done   = spur;
      h.abort = (sc == ast);
      @(posedge clk); #1;
      done    = 1'b0;
      h.abort = 1'b0;
      if (sc == ast) break;
    end
    check_eq("start_lo", start, 0);

    r = 0;
    while (!h.rsp_valid && r < TIMEOUT + 2) begin
      r++;
      if (r == 1) check_eq("run_busy", busy, 1);
      if (r == rst_at) begin
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_start", start, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rsp_valid", h.rsp_valid, 0);
        check_eq("rst_req_ready", h.req_ready, 1);
        check_eq("rst_rsp_cycles", h.rsp_cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      done    = (r == d_at);
      h.abort = (r == a_at);
      @(posedge clk); #1;
      done    = 1'b0;
      h.abort = 1'b0;
    end

    check_eq("run_len", r, exp_cyc);
    check_eq("rsp_valid", h.rsp_valid, 1);
    check_eq("rsp_busy", busy, 0);
    check_eq("rsp_cycles", h.rsp_cycles, exp_cyc);
    check_eq("rsp_timeout", h.rsp_timeout, exp_to);
    check_eq("rsp_aborted", h.rsp_aborted, exp_ab);

    c0 = h.rsp_cycles;
    t0 = h.rsp_timeout;
    a0 = h.rsp_aborted;
    h.rsp_ready = 1'b0;
    h.req_valid = hold_req;
    for (int i = 0; i < bp; i++) begin
      done    = 1'b1;
      h.abort = 1'b1;
      @(posedge clk); #1;
      done    = 1'b0;
      h.abort = 1'b0;
      check_eq("bp_valid", h.rsp_valid, 1);
      check_eq("bp_cycles", h.rsp_cycles, c0);
      check_eq("bp_flags", {h.rsp_timeout, h.rsp_aborted}, {t0, a0});
      check_eq("bp_req_ready", h.req_ready, 0);
      check_eq("bp_start", start, 0);
    end
    h.rsp_ready = 1'b1;
    @(posedge clk); #1;
    h.rsp_ready = 1'b0;
    check_eq("ack_valid", h.rsp_valid, 0);
    check_eq("ack_req_ready", h.req_ready, 1);
    check_eq("ack_start", start, 0);
    check_eq("ack_hold", h.rsp_cycles, c0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    done        = 1'b0;
    h.req_valid = 1'b0;
    h.abort     = 1'b0;
    h.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_start", start, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_rsp_valid", h.rsp_valid, 0);
    check_eq("reset_req_ready", h.req_ready, 1);
    check_eq("reset_fields", {h.rsp_cycles, h.rsp_timeout, h.rsp_aborted}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // abort in IDLE has no effect
    h.abort = 1'b1;
    @(posedge clk); #1;
    h.abort = 1'b0;
    check_eq("idle_abort_ignored", {busy, start, h.rsp_valid}, 0);

    do_run(37, 0, 0, 1'b0, 0, 1'b0, 0);
    do_run(0, 0, 0, 1'b0, 0, 1'b0, 0);
    do_run(5, 0, 0, 1'b1, 0, 1'b0, 0);
    do_run(9, 0, 0, 1'b0, 10, 1'b1, 0);
    do_run(3, 0, 0, 1'b0, 0, 1'b0, 0);
    do_run(0, 12, 0, 1'b0, 0, 1'b0, 0);
    do_run(8, 8, 0, 1'b0, 0, 1'b0, 0);
    do_run(0, 0, 2, 1'b1, 1, 1'b0, 0);
    do_run(0, 0, 1, 1'b0, 0, 1'b0, 0);
    do_run(TIMEOUT, 0, 0, 1'b0, 0, 1'b0, 0);
    do_run(0, TIMEOUT, 0, 1'b0, 0, 1'b0, 0);
    do_run(0, 0, 0, 1'b0, 0, 1'b0, 20);
    do_run(15, 0, 0, 1'b0, 0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      int d_at, a_at, ast, bp;
      bit spur, hold;
      d_at = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 80);
      a_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 80) : 0;
      ast  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, START_CYCLES) : 0;
      spur = 1'($urandom_range(0, 1));
      bp   = $urandom_range(0, 3);
      hold = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_run(d_at, a_at, ast, spur, bp, hold, 0);
    end
    h.req_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
Host-side sequencer that sits directly upstream of the processor top level and drives its start input. It also consumes the core's done output.
- Accepts a run request over a valid/ready handshake.
- Pulses start for a fixed number of cycles so the core's PC is forced to 0.
- Counts execution cycles until done, or until a timeout.
- Returns the cycle count and status over a valid/ready response channel.

Parameters:
CNT_W, 16, width of the cycle counter and rsp_cycles.
START_CYCLES, 2, number of consecutive cycles start is held high (legal range 1..15).
TIMEOUT, 1000, RUN-cycle limit before the run is declared hung. Must satisfy 1 <= TIMEOUT < 2^CNT_W.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  host requests a program run.
req_ready  output  1  controller can accept a request.
abort  input  1  host abort of the run in progress.
start  output  1  to core start; high forces the core's PC to 0.
done  input  1  from core done; single-cycle pulse when the halt instruction is fetched.
busy  output  1  run in progress (START or RUN state).
rsp_valid  output  1  result available.
rsp_ready  input  1  host accepts the result.
rsp_cycles  output  CNT_W  RUN cycles consumed.
rsp_timeout  output  1  run ended by timeout.
rsp_aborted  output  1  run ended by abort.

Behaviour:
- States: IDLE, START, RUN, REPORT. All outputs are registered (Moore), except req_ready, which is decoded as (state==IDLE).
- Reset (async, rst_n low):
  - state=IDLE, start=0, busy=0, rsp_valid=0.
  - rsp_cycles=0, rsp_timeout=0, rsp_aborted=0.
  - Internal counters are cleared.
  - Asserting reset mid-run drops start immediately and discards any pending result.
- IDLE:
  - req_ready=1.
  - On req_valid: go to START in the next cycle; start=1, busy=1, start counter cleared.
  - abort is ignored in IDLE.
- START:
  - start is held high for exactly START_CYCLES cycles, then deasserts with the transition to RUN.
  - The cycle counter is cleared on entry to RUN.
  - done is ignored in START; the core is parked at PC 0.
  - abort in START: go to REPORT with rsp_aborted=1, rsp_cycles=0, and start low in the next cycle.
- RUN (start=0, busy=1):
  - The counter increments once per cycle in RUN.
  - The first RUN cycle has count 1.
  - done sampled high: latch rsp_cycles=count for that cycle (including it) and rsp_timeout=0, then go to REPORT.
  - No done and count==TIMEOUT: latch rsp_cycles=TIMEOUT and rsp_timeout=1, then go to REPORT.
  - Priority within one cycle: done > abort > timeout.
    - done on the TIMEOUT cycle counts as success.
    - abort without done: rsp_aborted=1, rsp_cycles=current count.
- REPORT:
  - rsp_valid=1, busy=0, req_ready=0.
  - Response fields stay stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready: rsp_valid drops next cycle and state returns to IDLE.
  - Response fields keep their values until the next result is latched.
  - done, abort and req_valid are ignored in REPORT.
- Back-to-back operation: a req_valid held high through REPORT is accepted in the first IDLE cycle.
- The counter never wraps, because TIMEOUT bounds it below 2^CNT_W.

Test Plan:
- Reset then normal run (defaults):
  - Stimulus: req_valid pulse; done asserted on the 37th RUN cycle.
  - Required: start high exactly 2 cycles; rsp_valid=1 with rsp_cycles=37, rsp_timeout=0, rsp_aborted=0.
- Timeout:
  - Stimulus: request; done never asserts.
  - Required: after 1000 RUN cycles, rsp_cycles=1000, rsp_timeout=1; busy falls as rsp_valid rises.
- Spurious done during START:
  - Stimulus: done high in both START cycles, then done on RUN cycle 5.
  - Required: rsp_cycles=5; the early done pulses are ignored.
- Response backpressure:
  - Stimulus: hold rsp_ready=0 for 10 cycles after rsp_valid, and pulse req_valid during REPORT.
  - Required: rsp_valid and fields stable throughout; req_ready=0; the new request is accepted only after the rsp_ready handshake.
- Abort and collision:
  - Abort on RUN cycle 12 -> rsp_aborted=1, rsp_cycles=12.
  - Separate run: done and abort both high on RUN cycle 8 -> success, rsp_cycles=8, rsp_aborted=0.
- Async reset mid-run:
  - Stimulus: drop rst_n on RUN cycle 20, off a clock edge.
  - Required: start, busy and rsp_valid go 0 immediately; after release, req_ready=1 and a fresh run reports correct counts.
